// File: rtl/keycode_pkg.sv
// rtl/keycode_pkg.sv - shared key codes, slot sizing and FSM state type for the HID report generator
// Contents: NUM_SLOTS / NUM_KEYS sizing, EMPTY / ROLLOVER slot values,
// KEY_CODE[k] per key index, state_t, and a population-count helper.
package keycode_pkg;

  localparam int NUM_SLOTS = 6;
  localparam int NUM_KEYS  = 8;

  localparam logic [7:0] EMPTY    = 8'h00;
  localparam logic [7:0] ROLLOVER = 8'h01;

  // Key k: 0..3 = W, S, A, D (player 1); 4..7 = up, down, left, right arrows (player 2).
  localparam logic [7:0] KEY_CODE [NUM_KEYS] = '{8'd26, 8'd22, 8'd4, 8'd7,
                                                 8'd82, 8'd81, 8'd80, 8'd79};

  typedef enum logic [1:0] {IDLE, RELEASE, PRESS, PUBLISH} state_t;

  function automatic logic [3:0] count_keys(input logic [NUM_KEYS-1:0] keys);
    logic [3:0] n;
    n = '0;
    for (int k = 0; k < NUM_KEYS; k++) n = n + {3'b000, keys[k]};
    return n;
  endfunction

endpackage

// File: rtl/hid_slot_list.sv
// rtl/hid_slot_list.sv - six-entry compacting keycode list with remove and append operations
// Ports: Clk, Reset (sync, active-high); remove_en/remove_code drops a code and
// shifts the higher entries down; append_en/append_code writes the lowest free
// entry; slots_next is the contents after this cycle's operation; count is
// the number of occupied entries; full is set when all entries are occupied.
module hid_slot_list
  import keycode_pkg::*;
(
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      remove_en,
  input  logic [7:0]                remove_code,
  input  logic                      append_en,
  input  logic [7:0]                append_code,
  output logic [NUM_SLOTS-1:0][7:0] slots_next,
  output logic [2:0]                count,
  output logic                      full
);

  logic [NUM_SLOTS-1:0][7:0] slots_q;
  logic [NUM_SLOTS-1:0][7:0] shifted;
  logic [NUM_SLOTS-1:0]      at_or_above;
  logic                      found;

  // Every entry moved one position toward slot 0, with an empty entry entering at the top.
  assign shifted = {EMPTY, slots_q[NUM_SLOTS-1:1]};
  assign full    = (count == 3'(NUM_SLOTS));

  always_comb begin
    found       = 1'b0;
    at_or_above = '0;
    // Entries at or above the matching one take their upper neighbour.
    for (int i = 0; i < NUM_SLOTS; i++) begin
      found          = found | (slots_q[i] == remove_code);
      at_or_above[i] = found;
    end
    slots_next = slots_q;
    if (remove_en) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (at_or_above[i]) slots_next[i] = shifted[i];
      end
    end else if (append_en && !full) begin
      // The list is kept compact, so the lowest free entry is at index count.
      slots_next[count] = append_code;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      slots_q <= '0;
      count   <= '0;
    end else begin
      slots_q <= slots_next;
      if (remove_en && found)         count <= count - 3'd1;
      else if (append_en && !full)    count <= count + 3'd1;
    end
  end

endmodule

// File: rtl/keycode_report_gen.sv
// rtl/keycode_report_gen.sv - builds 6-slot HID boot keycode reports from per-player direction commands
// Ports: Clk, Reset (sync, active-high); command_p1 {up,down,left,right} -> W,S,A,D;
// command_p2 {up,down,left,right} -> arrow keys; keycode_0..keycode_5 report
// slots (0 = empty, all 8'h01 on rollover); report_valid / report_ready handshake.
module keycode_report_gen
  import keycode_pkg::*;
#(
  parameter int IDLE_REPEAT = 0,
  parameter int REPEAT_W    = 24
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] command_p1,
  input  logic [3:0] command_p2,
  output logic [7:0] keycode_0,
  output logic [7:0] keycode_1,
  output logic [7:0] keycode_2,
  output logic [7:0] keycode_3,
  output logic [7:0] keycode_4,
  output logic [7:0] keycode_5,
  output logic       report_valid,
  input  logic       report_ready
);

  localparam bit                  REPEAT_EN = (IDLE_REPEAT != 0);
  localparam logic [REPEAT_W-1:0] REP_LAST  =
    REPEAT_W'((IDLE_REPEAT > 0) ? IDLE_REPEAT - 1 : 0);

  state_t                    state, state_next;
  logic [7:0]                cmd_vec;
  logic [NUM_KEYS-1:0]       cmd_keys;
  logic [NUM_KEYS-1:0]       snap, last, in_slot;
  logic [2:0]                idx;
  logic [REPEAT_W-1:0]       rep_cnt;
  logic [NUM_SLOTS-1:0][7:0] keycodes_q;
  logic [NUM_SLOTS-1:0][7:0] slots_next;
  logic [2:0]                list_count_unused;
  logic                      list_full;
  logic                      remove_en, append_en, publish_load;
  logic                      rollover;

  // Key index 0 is the MSB of {command_p1, command_p2}; bit k of cmd_keys is key k.
  assign cmd_vec = {command_p1, command_p2};
  always_comb begin
    cmd_keys = '0;
    for (int k = 0; k < NUM_KEYS; k++) cmd_keys[k] = cmd_vec[NUM_KEYS-1-k];
  end

  assign rollover = (count_keys(snap) > 4'd6);

  hid_slot_list u_slots (
    .Clk         (Clk),
    .Reset       (Reset),
    .remove_en   (remove_en),
    .remove_code (KEY_CODE[idx]),
    .append_en   (append_en),
    .append_code (KEY_CODE[idx]),
    .slots_next  (slots_next),
    .count       (list_count_unused),
    .full        (list_full)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    remove_en    = 1'b0;
    append_en    = 1'b0;
    publish_load = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_keys != last)                         state_next = RELEASE;
        else if (REPEAT_EN && (rep_cnt == REP_LAST))  state_next = PUBLISH;
      end
      RELEASE: begin
        remove_en = in_slot[idx] & ~snap[idx];
        if (idx == 3'd7) state_next = PRESS;
      end
      PRESS: begin
        // A key that finds no free slot stays out of in_slot and is retried next scan.
        append_en = snap[idx] & ~in_slot[idx] & ~list_full;
        if (idx == 3'd7) begin
          state_next   = PUBLISH;
          publish_load = 1'b1;
        end
      end
      PUBLISH: begin
        if (report_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      snap       <= '0;
      last       <= '0;
      in_slot    <= '0;
      idx        <= '0;
      rep_cnt    <= '0;
      keycodes_q <= '0;
    end else begin
      rep_cnt <= '0;
      case (state)
        IDLE: begin
          snap <= cmd_keys;
          idx  <= '0;
          if (REPEAT_EN && (state_next == IDLE)) rep_cnt <= rep_cnt + 1'b1;
        end
        RELEASE: begin
          if (remove_en) in_slot[idx] <= 1'b0;
          idx <= idx + 3'd1;
        end
        PRESS: begin
          if (append_en) in_slot[idx] <= 1'b1;
          idx <= idx + 3'd1;
          // slots_next already includes the append of the final key.
          if (publish_load) begin
            last       <= snap;
            keycodes_q <= rollover ? {NUM_SLOTS{ROLLOVER}} : slots_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign report_valid = (state == PUBLISH);
  assign keycode_0    = keycodes_q[0];
  assign keycode_1    = keycodes_q[1];
  assign keycode_2    = keycodes_q[2];
  assign keycode_3    = keycodes_q[3];
  assign keycode_4    = keycodes_q[4];
  assign keycode_5    = keycodes_q[5];

endmodule

// File: tb/tb_keycode_report_gen.sv
// tb/tb_keycode_report_gen.sv - self-checking bench for keycode_report_gen
module tb_keycode_report_gen;

  logic       Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Reset, report_ready, report_valid;
  logic [3:0] command_p1, command_p2;
  logic [7:0] keycode_0, keycode_1, keycode_2, keycode_3, keycode_4, keycode_5;
  logic       rep_reset, rep_ready, rep_valid;
  logic [3:0] rep_p1, rep_p2;
  logic [7:0] rk0, rk1, rk2, rk3, rk4, rk5;
  logic [47:0] codes, rep_codes_now;

  assign codes         = {keycode_5, keycode_4, keycode_3, keycode_2, keycode_1, keycode_0};
  assign rep_codes_now = {rk5, rk4, rk3, rk2, rk1, rk0};

  keycode_report_gen #(.IDLE_REPEAT(0), .REPEAT_W(24)) dut (
    .Clk(Clk), .Reset(Reset), .command_p1(command_p1), .command_p2(command_p2),
    .keycode_0(keycode_0), .keycode_1(keycode_1), .keycode_2(keycode_2),
    .keycode_3(keycode_3), .keycode_4(keycode_4), .keycode_5(keycode_5),
    .report_valid(report_valid), .report_ready(report_ready)
  );

  keycode_report_gen #(.IDLE_REPEAT(100), .REPEAT_W(24)) dut_rep (
    .Clk(Clk), .Reset(rep_reset), .command_p1(rep_p1), .command_p2(rep_p2),
    .keycode_0(rk0), .keycode_1(rk1), .keycode_2(rk2),
    .keycode_3(rk3), .keycode_4(rk4), .keycode_5(rk5),
    .report_valid(rep_valid), .report_ready(rep_ready)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  p1;
    logic [3:0]  p2;
    logic [47:0] exp;
  } vec_t;

  // Reference model: ordered list of held codes, rebuilt from press/release rules.
  int         kc [8] = '{26, 22, 4, 7, 82, 81, 80, 79};
  int         mq [$];
  bit         mheld [8];
  logic [7:0] mlast;

  // Monitor for the repeating instance.
  int          rep_cyc = 0;
  int          rep_pulse [$];
  logic [47:0] rep_codes [$];

  always @(posedge Clk) begin
    #1;
    rep_cyc++;
    if (rep_valid === 1'b1) begin
      rep_pulse.push_back(rep_cyc);
      rep_codes.push_back(rep_codes_now);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [47:0] got, input logic [47:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int k = 0; k < 8; k++) mheld[k] = 1'b0;
    mlast = 8'h00;
  endtask

  task automatic model_scan(input logic [7:0] v, output logic [47:0] want);
    bit key [8];
    int n;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      key[k] = v[7-k];
      n += int'(key[k]);
    end
    for (int k = 0; k < 8; k++) begin
      if (mheld[k] && !key[k]) begin
        for (int j = 0; j < mq.size(); j++) begin
          if (mq[j] == kc[k]) begin
            mq.delete(j);
            break;
          end
        end
        mheld[k] = 1'b0;
      end
    end
    for (int k = 0; k < 8; k++) begin
      if (key[k] && !mheld[k] && mq.size() < 6) begin
        mq.push_back(kc[k]);
        mheld[k] = 1'b1;
      end
    end
    want = '0;
    if (n > 6) want = {6{8'h01}};
    else for (int s = 0; s < mq.size(); s++) want[s*8 +: 8] = 8'(mq[s]);
    mlast = v;
  endtask

  // Counts edges from the input change until report_valid; 17 are required.
  task automatic wait_report(input string name, input int start);
    int lat;
    lat = start;
    while (report_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    chk({name, "_latency"}, 48'(lat), 48'd17);
  endtask

  task automatic finish_report(input string name, input logic [47:0] want, input int hold);
    logic        ok;
    logic [47:0] seen;
    chk({name, "_codes"}, codes, want);
    seen = codes;
    ok   = 1'b1;
    repeat (hold) begin
      tick();
      if (report_valid !== 1'b1 || codes !== seen) ok = 1'b0;
    end
    chk({name, "_hold"}, 48'(ok), 48'd1);
    report_ready = 1'b1;
    tick();
    report_ready = 1'b0;
    chk({name, "_drop"}, 48'(report_valid), 48'd0);
  endtask

  initial begin
    vec_t        tbl [8];
    logic [47:0] want;
    logic        ok;
    logic [7:0]  v;

    tbl[0] = '{4'b1000, 4'b0000, {40'h0, 8'd26}};
    tbl[1] = '{4'b1000, 4'b0001, {32'h0, 8'd79, 8'd26}};
    tbl[2] = '{4'b0000, 4'b0001, {40'h0, 8'd79}};
    tbl[3] = '{4'b0000, 4'b0000, 48'h0};
    tbl[4] = '{4'b1111, 4'b1111, {6{8'h01}}};
    tbl[5] = '{4'b1100, 4'b1111, {8'd79, 8'd80, 8'd81, 8'd82, 8'd22, 8'd26}};
    tbl[6] = '{4'b0000, 4'b1000, {40'h0, 8'd82}};
    tbl[7] = '{4'b0010, 4'b1000, {32'h0, 8'd4, 8'd82}};

    Reset        = 1'b1;
    rep_reset    = 1'b1;
    command_p1   = 4'b0000;
    command_p2   = 4'b0000;
    report_ready = 1'b0;
    rep_ready    = 1'b1;
    rep_p1       = 4'b1000;
    rep_p2       = 4'b0000;
    repeat (3) tick();
    chk("reset_codes", codes, 48'h0);
    chk("reset_valid", 48'(report_valid), 48'd0);
    Reset     = 1'b0;
    rep_reset = 1'b0;

    ok = 1'b1;
    repeat (100) begin
      tick();
      if (report_valid !== 1'b0 || codes !== 48'h0) ok = 1'b0;
    end
    chk("idle_quiet", 48'(ok), 48'd1);

    model_reset();
    for (int i = 0; i < 8; i++) begin
      command_p1 = tbl[i].p1;
      command_p2 = tbl[i].p2;
      model_scan({tbl[i].p1, tbl[i].p2}, want);
      wait_report($sformatf("tbl%0d", i), 0);
      finish_report($sformatf("tbl%0d", i), tbl[i].exp, (i == 0) ? 5 : i % 3);
    end

    // Input toggles mid-PRESS: first report uses the old snapshot, a second follows.
    command_p1 = 4'b0010;
    command_p2 = 4'b0000;
    repeat (12) tick();
    command_p2 = 4'b1000;
    wait_report("glitch1", 12);
    finish_report("glitch1", {40'h0, 8'd4}, 1);
    wait_report("glitch2", 0);
    finish_report("glitch2", {32'h0, 8'd82, 8'd4}, 0);

    // Reset in the middle of the RELEASE scan (idx 3).
    command_p1 = 4'b1000;
    command_p2 = 4'b0000;
    repeat (4) tick();
    Reset = 1'b1;
    tick();
    chk("midscan_reset_valid", 48'(report_valid), 48'd0);
    chk("midscan_reset_codes", codes, 48'h0);
    Reset = 1'b0;
    model_reset();
    model_scan(8'h80, want);
    wait_report("post_reset", 0);
    finish_report("post_reset", want, 0);

    for (int i = 0; i < 30; i++) begin
      v = 8'($urandom);
      if (v == mlast) v = v ^ (8'h01 << $urandom_range(0, 7));
      command_p1 = v[7:4];
      command_p2 = v[3:0];
      model_scan(v, want);
      wait_report($sformatf("rnd%0d", i), 0);
      finish_report($sformatf("rnd%0d", i), want, $urandom_range(0, 2));
    end

    ok = 1'b1;
    repeat (300) begin
      tick();
      if (report_valid !== 1'b0) ok = 1'b0;
    end
    chk("no_repeat_when_disabled", 48'(ok), 48'd1);

    chk("rep_pulse_count", 48'(rep_pulse.size() >= 4), 48'd1);
    ok = 1'b1;
    for (int i = 1; i < rep_pulse.size(); i++) begin
      if (rep_pulse[i] - rep_pulse[i-1] != 101) ok = 1'b0;
    end
    chk("rep_period", 48'(ok), 48'd1);
    ok = 1'b1;
    for (int i = 0; i < rep_codes.size(); i++) begin
      if (rep_codes[i] !== {40'h0, 8'd26}) ok = 1'b0;
    end
    chk("rep_codes", 48'(ok), 48'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
